// File: rtl/shift_result_fifo_pkg.sv
// rtl/shift_result_fifo_pkg.sv - shared flag indices and entry sizing for shift_result_fifo
package shift_result_fifo_pkg;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_COUT = 2;
    localparam int FLAG_W    = 3;

    // Stored entry is {flags, data}, so flags sit directly above the data bits.
    function automatic int entry_w(input int width);
        return width + FLAG_W;
    endfunction

endpackage

// File: rtl/shift_result_fifo_ptr.sv
// rtl/shift_result_fifo_ptr.sv - modulo-DEPTH pointer with synchronous active-low clear
module fifo_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   ptr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == PW'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/shift_result_fifo.sv
// rtl/shift_result_fifo.sv - result/flag FIFO downstream of the 16-bit shift/rotate ALU
module shift_result_fifo
    import shift_result_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_cout,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [FLAG_W-1:0]              out_flags,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int EW = entry_w(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [FLAG_W-1:0] in_flags;
    logic [EW-1:0]     head;

    // Handshake state comes from count_q alone, so in_ready never sees out_ready.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        in_flags            = '0;
        in_flags[FLAG_ZERO] = (in_data == '0);
        in_flags[FLAG_NEG]  = in_data[WIDTH-1];
        in_flags[FLAG_COUT] = in_cout;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr] = {in_flags, in_data};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not cleared; out_valid gating hides stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head      = mem_q[rd_ptr];
    assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
    assign out_flags = out_valid ? head[EW-1:WIDTH] : '0;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (push),
        .ptr    (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (pop),
        .ptr    (rd_ptr)
    );

endmodule

// File: tb/tb_shift_result_fifo.sv
// tb/tb_shift_result_fifo.sv - directed self-checking bench for shift_result_fifo
module tb_shift_result_fifo;

    logic        clk;
    logic        reset_;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int passed = 0;
    int total  = 0;

    logic        prev_hold = 1'b0;
    logic        prev_rst  = 1'b0;
    logic [15:0] prev_data = '0;
    logic [2:0]  prev_flags = '0;

    shift_result_fifo #(.WIDTH(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consumer-side rule: a stalled head must not change.
    always @(negedge clk) begin
        if (prev_hold && prev_rst) begin
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_flags", 32'(out_flags), 32'(prev_flags));
        end
        prev_hold  = out_valid && !out_ready;
        prev_rst   = reset_;
        prev_data  = out_data;
        prev_flags = out_flags;
    end

    initial begin
        reset_    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        in_cout   = 1'b1;
        out_ready = 1'b0;

        // 1. reset with in_valid asserted
        step();
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);

        // 2. single result
        reset_   = 1'b1;
        in_data  = 16'h8001;
        in_cout  = 1'b1;
        chk("no_bypass", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h8001);
        chk("single_flags", 32'(out_flags), 32'b110);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_empty", 32'(empty), 32'd1);
        chk("single_pop_data", 32'(out_data), 32'd0);

        // 3. zero flag
        in_valid = 1'b1;
        in_data  = 16'h0000;
        in_cout  = 1'b0;
        step();
        in_valid = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_flags", 32'(out_flags), 32'b001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("zero_pop_empty", 32'(empty), 32'd1);

        // 4. fill across the pointer wrap (pointers start at 2)
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 16'hA000 + 16'(i);
            in_cout = i[0];
            step();
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_head", 32'(out_data), 32'hA001);
        chk("fill_head_flags", 32'(out_flags), 32'b110);
        in_data = 16'hA005;
        in_cout = 1'b0;
        step();
        chk("fill_held_count", 32'(count), 32'd4);
        chk("fill_held_head", 32'(out_data), 32'hA001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full_pop_no_push", 32'(count), 32'd3);
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        chk("full_pop_head", 32'(out_data), 32'hA002);
        chk("full_pop_flags", 32'(out_flags), 32'b010);
        step();
        in_valid = 1'b0;
        chk("fifth_accepted", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("drain_A%0d", i), 32'(out_data), 32'hA000 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // 5. steady push/pop at count=2
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'hB000 + 16'(i);
            in_cout = 1'b0;
            step();
        end
        chk("stream_prefill", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'hB002 + 16'(i);
            chk($sformatf("stream_head_%0d", i), 32'(out_data), 32'hB000 + 32'(i));
            step();
            chk($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        chk("stream_tail_0", 32'(out_data), 32'hB00A);
        step();
        chk("stream_tail_1", 32'(out_data), 32'hB00B);
        step();
        out_ready = 1'b0;
        chk("stream_empty", 32'(empty), 32'd1);

        // 6. reset mid-stream
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'hC000 + 16'(i);
            step();
        end
        chk("mid_count3", 32'(count), 32'd3);
        reset_  = 1'b0;
        in_data = 16'hC004;
        step();
        reset_   = 1'b1;
        in_valid = 1'b0;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_cout  = 1'b0;
        step();
        in_valid = 1'b0;
        chk("fresh_data", 32'(out_data), 32'h1234);
        chk("fresh_flags", 32'(out_flags), 32'b000);
        chk("fresh_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fresh_pop_empty", 32'(empty), 32'd1);

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
